// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the RV32I instruction/data memory responder.
// Channel states and byte-lane mask expansion.
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } chan_state_e;

   // Widest data bus the mask helper covers, in byte lanes.
   localparam int MAX_LANES = 16;

   function automatic logic [8*MAX_LANES-1:0] byte_mask(
      input logic [MAX_LANES-1:0] m
   );
      logic [8*MAX_LANES-1:0] b;
      for (int i = 0; i < MAX_LANES; i++) begin
         b[8*i +: 8] = {8{m[i]}};
      end
      return b;
   endfunction

endpackage

// File: rtl/riscv_mem_chan.sv
// One request channel: IDLE/WAIT/RESP sequencer with a latency counter.
// accept/go_resp/commit are same-cycle strobes; ready is a state decode.
module riscv_mem_chan
   import riscv_mem_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic accept,
   output logic go_resp,
   output logic commit,
   output logic ready
);

   localparam int CW = (LAT > 2) ? $clog2(LAT - 1) : 1;

   chan_state_e   state;
   logic [CW-1:0] cnt;

   assign accept = en && (state != WAIT);
   assign commit = (state == RESP) && !reset;
   assign ready  = (state == RESP);

   // Entering RESP on this edge: direct from accept, or end of WAIT.
   assign go_resp = (LAT == 1) ? accept
                  : (state == WAIT) && en && (cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE, RESP: begin
               if (!en) begin
                  state <= IDLE;
               end else if (LAT == 1) begin
                  state <= RESP;
               end else begin
                  state <= WAIT;
                  cnt   <= CW'(LAT - 2);
               end
            end
            WAIT: begin
               if (!en) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == '0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/riscv_mem_model.sv
// Instruction/data memory responder for the RV32I core: wait states,
// byte-masked stores, range errors and a backdoor preload port.
module riscv_mem_model
   import riscv_mem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024,
   parameter int IMEM_LAT   = 1,
   parameter int DMEM_LAT   = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inst_rd_en,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic                instr_ready,
   output logic [DATA_W-1:0]   instr_data,
   output logic                instr_err,
   input  logic                data_rd_en_ma,
   input  logic                data_wr_en_ma,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wr,
   input  logic [DATA_W/8-1:0] data_rd_en_ctrl,
   output logic                data_ready,
   output logic [DATA_W-1:0]   data_rd,
   output logic                data_err,
   input  logic                ld_en,
   input  logic                ld_sel,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_data
);

   localparam int NB  = DATA_W / 8;
   localparam int WIW = ADDR_W - 2;
   localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

   logic [DATA_W-1:0] imem [IMEM_DEPTH];
   logic [DATA_W-1:0] dmem [DMEM_DEPTH];

   // ---------------- instruction channel ----------------
   logic           i_acc, i_go;
   logic [WIW-1:0] i_idx_q, i_idx;
   logic           i_ok;

   riscv_mem_chan #(.LAT(IMEM_LAT)) u_ichan (
      .clk     (clk),
      .reset   (reset),
      .en      (inst_rd_en),
      .accept  (i_acc),
      .go_resp (i_go),
      .commit  (),
      .ready   (instr_ready)
   );

   assign i_idx = i_acc ? inst_addr[ADDR_W-1:2] : i_idx_q;
   assign i_ok  = i_idx < WIW'(IMEM_DEPTH);

   always_ff @(posedge clk) begin
      if (i_acc) i_idx_q <= inst_addr[ADDR_W-1:2];
   end

   always_ff @(posedge clk) begin
      if (reset || !i_go) begin
         instr_data <= '0;
         instr_err  <= 1'b0;
      end else begin
         instr_data <= i_ok ? imem[i_idx[IAW-1:0]] : '0;
         instr_err  <= !i_ok;
      end
   end

   // ---------------- data channel ----------------
   logic              d_en, d_acc, d_go, d_commit;
   logic [WIW-1:0]    d_idx_q, d_idx;
   logic [DATA_W-1:0] d_wd_q;
   logic [NB-1:0]     d_m_q, d_m;
   logic              d_wr_q, d_rd_q, d_wrop, d_rdop;
   logic              d_ok, d_ok_q, wr_hit;
   logic [DATA_W-1:0] bm_q, bm_cur, d_word;
   logic [8*MAX_LANES-1:0] bmf_q, bmf_cur;

   assign d_en = data_rd_en_ma || data_wr_en_ma;

   riscv_mem_chan #(.LAT(DMEM_LAT)) u_dchan (
      .clk     (clk),
      .reset   (reset),
      .en      (d_en),
      .accept  (d_acc),
      .go_resp (d_go),
      .commit  (d_commit),
      .ready   (data_ready)
   );

   always_ff @(posedge clk) begin
      if (d_acc) begin
         d_idx_q <= data_addr[ADDR_W-1:2];
         d_wd_q  <= data_wr;
         d_m_q   <= data_rd_en_ctrl;
         d_wr_q  <= data_wr_en_ma;
         d_rd_q  <= data_rd_en_ma;
      end
   end

   // With LAT=1 the response is built on the accept edge itself.
   assign d_idx  = d_acc ? data_addr[ADDR_W-1:2] : d_idx_q;
   assign d_m    = d_acc ? data_rd_en_ctrl : d_m_q;
   assign d_wrop = d_acc ? data_wr_en_ma : d_wr_q;
   assign d_rdop = d_acc ? data_rd_en_ma : d_rd_q;

   assign d_ok   = d_idx < WIW'(DMEM_DEPTH);
   assign d_ok_q = d_idx_q < WIW'(DMEM_DEPTH);
   assign wr_hit = d_commit && d_wr_q && d_ok_q;

   assign bmf_q   = byte_mask(MAX_LANES'(d_m_q));
   assign bmf_cur = byte_mask(MAX_LANES'(d_m));
   assign bm_q    = bmf_q[DATA_W-1:0];
   assign bm_cur  = bmf_cur[DATA_W-1:0];

   logic pl_i, pl_d;
   assign pl_i = ld_en && !ld_sel && (ld_addr < ADDR_W'(IMEM_DEPTH));
   assign pl_d = ld_en &&  ld_sel && (ld_addr < ADDR_W'(DMEM_DEPTH));

   // Forward same-edge store and preload so a following load sees them.
   always_comb begin
      d_word = d_ok ? dmem[d_idx[DAW-1:0]] : '0;
      if (wr_hit && (d_idx_q == d_idx)) begin
         d_word = (d_word & ~bm_q) | (d_wd_q & bm_q);
      end
      if (pl_d && (ld_addr == {2'b00, d_idx})) begin
         d_word = ld_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !d_go) begin
         data_rd  <= '0;
         data_err <= 1'b0;
      end else begin
         data_rd  <= (d_wrop || !d_ok) ? '0 : (d_word & bm_cur);
         data_err <= !d_ok || (d_wrop && d_rdop);
      end
   end

   // Arrays have no reset; preload is issued last so it wins a tie.
   always_ff @(posedge clk) begin
      if (wr_hit) begin
         dmem[d_idx_q[DAW-1:0]] <=
            (dmem[d_idx_q[DAW-1:0]] & ~bm_q) | (d_wd_q & bm_q);
      end
      if (pl_d) dmem[ld_addr[DAW-1:0]] <= ld_data;
   end

   always_ff @(posedge clk) begin
      if (pl_i) imem[ld_addr[IAW-1:0]] <= ld_data;
   end

endmodule

// File: tb/tb_riscv_mem_model.sv
// Directed bench for riscv_mem_model with a transaction-level model
// checked every cycle plus literal expectations at key points.
module tb_riscv_mem_model;

   localparam int IL = 1;
   localparam int DL = 3;
   localparam int ID = 64;
   localparam int DD = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_rd_en = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic        instr_err;
   logic        data_rd_en_ma = 1'b0;
   logic        data_wr_en_ma = 1'b0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wr = '0;
   logic [3:0]  data_rd_en_ctrl = '0;
   logic        data_ready;
   logic [31:0] data_rd;
   logic        data_err;
   logic        ld_en = 1'b0;
   logic        ld_sel = 1'b0;
   logic [31:0] ld_addr = '0;
   logic [31:0] ld_data = '0;

   int checks = 0;
   int fails = 0;

   always #5 clk = ~clk;

   riscv_mem_model #(
      .DATA_W(32), .ADDR_W(32),
      .IMEM_DEPTH(ID), .DMEM_DEPTH(DD),
      .IMEM_LAT(IL), .DMEM_LAT(DL)
   ) dut (
      .clk(clk), .reset(reset),
      .inst_rd_en(inst_rd_en), .inst_addr(inst_addr),
      .instr_ready(instr_ready), .instr_data(instr_data),
      .instr_err(instr_err),
      .data_rd_en_ma(data_rd_en_ma), .data_wr_en_ma(data_wr_en_ma),
      .data_addr(data_addr), .data_wr(data_wr),
      .data_rd_en_ctrl(data_rd_en_ctrl),
      .data_ready(data_ready), .data_rd(data_rd), .data_err(data_err),
      .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   // ---------------- reference model ----------------
   logic [31:0] mi [ID];
   logic [31:0] md [DD];
   int  ec = 0;
   bit  armed = 0;
   bit  iv = 0, dv = 0;
   int  ia, da;
   logic [31:0] iaddr, daddr, dwd;
   logic [3:0]  dm;
   bit  dwr, drd;
   logic e_ir, e_ie, e_dr, e_de;
   logic [31:0] e_id, e_dd;

   function automatic logic [31:0] bm4(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

   always @(posedge clk) begin : model
      logic [31:0] wi;
      ec++;
      armed = 1;
      if (reset) begin
         iv = 0;
         dv = 0;
      end else begin
         if (dv && ec == da + DL) begin
            wi = daddr >> 2;
            if (dwr && wi < DD)
               md[wi] = (md[wi] & ~bm4(dm)) | (dwd & bm4(dm));
            dv = 0;
         end
         if (iv && ec == ia + IL) iv = 0;
         if (dv && !(data_rd_en_ma || data_wr_en_ma)) dv = 0;
         if (iv && !inst_rd_en) iv = 0;
      end
      if (ld_en && !ld_sel && ld_addr < ID) mi[ld_addr] = ld_data;
      if (ld_en &&  ld_sel && ld_addr < DD) md[ld_addr] = ld_data;
      if (!reset) begin
         if (!iv && inst_rd_en) begin
            iv = 1; ia = ec; iaddr = inst_addr;
         end
         if (!dv && (data_rd_en_ma || data_wr_en_ma)) begin
            dv = 1; da = ec; daddr = data_addr; dwd = data_wr;
            dm = data_rd_en_ctrl; dwr = data_wr_en_ma; drd = data_rd_en_ma;
         end
      end
      e_ir = iv && (ec == ia + IL - 1);
      wi   = iaddr >> 2;
      e_ie = e_ir && (wi >= ID);
      e_id = (e_ir && wi < ID) ? mi[wi] : 32'h0;
      e_dr = dv && (ec == da + DL - 1);
      wi   = daddr >> 2;
      e_de = e_dr && ((wi >= DD) || (drd && dwr));
      e_dd = (e_dr && !dwr && wi < DD) ? (md[wi] & bm4(dm)) : 32'h0;
   end

   always @(negedge clk) begin
      if (armed) begin
         checks++;
         if ({instr_ready, instr_err, instr_data} !== {e_ir, e_ie, e_id}) begin
            fails++;
            $display("FAIL imem_cyc%0d: got rdy=%b err=%b d=%h want rdy=%b err=%b d=%h",
                     ec, instr_ready, instr_err, instr_data, e_ir, e_ie, e_id);
         end
         checks++;
         if ({data_ready, data_err, data_rd} !== {e_dr, e_de, e_dd}) begin
            fails++;
            $display("FAIL dmem_cyc%0d: got rdy=%b err=%b d=%h want rdy=%b err=%b d=%h",
                     ec, data_ready, data_err, data_rd, e_dr, e_de, e_dd);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic preload(input bit sel, input int idx, input logic [31:0] d);
      ld_en = 1; ld_sel = sel; ld_addr = idx; ld_data = d;
      @(posedge clk); #1;
      ld_en = 0;
   endtask

   task automatic wait_rdy(output int lat);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (data_ready) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic dop(input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] m,
                      output logic [31:0] rdata, output logic err,
                      output int lat);
      data_rd_en_ma = rd; data_wr_en_ma = wr; data_addr = a;
      data_wr = wd; data_rd_en_ctrl = m;
      @(posedge clk);
      wait_rdy(lat);
      rdata = data_rd;
      err = data_err;
      data_rd_en_ma = 0; data_wr_en_ma = 0;
      @(posedge clk); #1;
   endtask

   logic [31:0] ilit [4] = '{32'h00000013, 32'h11111111,
                             32'h22222222, 32'h33333333};

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat, seen, t1, t2;

      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_iready", 32'(instr_ready), 0);
      chk("rst_dready", 32'(data_ready), 0);
      chk("rst_idata", instr_data, 0);
      chk("rst_drd", data_rd, 0);
      chk("rst_errs", {30'd0, instr_err, data_err}, 0);
      @(posedge clk); #1;

      for (int i = 0; i < ID; i++)
         preload(0, i, (i < 4) ? ilit[i] : 32'h10000000 + i);
      for (int i = 0; i < DD; i++)
         preload(1, i, 32'hC0DE0000 | i);
      preload(1, 4, 32'hDEADBEEF);
      preload(1, 8, 32'h00000000);
      preload(1, DD, 32'hBAD0BAD0);

      // back-to-back fetches
      inst_rd_en = 1; inst_addr = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i < 3) inst_addr = 4 * (i + 1);
         else inst_rd_en = 0;
         @(negedge clk);
         chk($sformatf("burst_rdy%0d", i), 32'(instr_ready), 1);
         chk($sformatf("burst_dat%0d", i), instr_data, ilit[i]);
      end
      @(posedge clk); #1;

      // out-of-range fetch
      inst_rd_en = 1; inst_addr = 32'h100;
      @(posedge clk); #1;
      inst_rd_en = 0;
      @(negedge clk);
      chk("ifetch_oor_err", 32'(instr_err), 1);
      chk("ifetch_oor_dat", instr_data, 0);
      @(posedge clk); #1;

      dop(1, 0, 32'h10, 0, 4'b0011, rd, er, lat);
      chk("ld_lat", lat, 3);
      chk("ld_masked", rd, 32'h0000BEEF);

      dop(0, 1, 32'h20, 32'hAABBCCDD, 4'b0100, rd, er, lat);
      chk("st_rd_zero", rd, 0);
      dop(1, 0, 32'h20, 0, 4'hF, rd, er, lat);
      chk("st_lane2", rd, 32'h00BB0000);

      dop(1, 0, 32'h100, 0, 4'hF, rd, er, lat);
      chk("oor_ld_lat", lat, 3);
      chk("oor_ld_dat", rd, 0);
      chk("oor_ld_err", 32'(er), 1);
      dop(0, 1, 32'h100, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      chk("oor_st_err", 32'(er), 1);
      dop(1, 0, 32'h0, 0, 4'hF, rd, er, lat);
      chk("oor_no_alias", rd, 32'hC0DE0000);

      // store dropped in WAIT
      data_wr_en_ma = 1; data_addr = 32'h24;
      data_wr = 32'h12345678; data_rd_en_ctrl = 4'hF;
      @(posedge clk);
      @(negedge clk);
      data_wr_en_ma = 0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (data_ready) seen++;
      end
      @(posedge clk); #1;
      chk("abort_no_ready", seen, 0);
      dop(1, 0, 32'h24, 0, 4'hF, rd, er, lat);
      chk("abort_mem", rd, 32'hC0DE0009);

      // reset during WAIT
      data_rd_en_ma = 1; data_addr = 32'h10; data_rd_en_ctrl = 4'hF;
      @(posedge clk);
      @(negedge clk);
      reset = 1;
      @(posedge clk); #1;
      reset = 0; data_rd_en_ma = 0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (data_ready || data_err || data_rd != 0) seen++;
      end
      @(posedge clk); #1;
      chk("rst_wait_quiet", seen, 0);

      // reset during RESP of a store
      data_wr_en_ma = 1; data_addr = 32'h30;
      data_wr = 32'hFFFFFFFF; data_rd_en_ctrl = 4'hF;
      @(posedge clk);
      wait_rdy(lat);
      chk("rst_resp_lat", lat, 3);
      reset = 1; data_wr_en_ma = 0;
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("rst_resp_ready", 32'(data_ready), 0);
      @(posedge clk); #1;
      dop(1, 0, 32'h30, 0, 4'hF, rd, er, lat);
      chk("rst_resp_nowr", rd, 32'hC0DE000C);

      // read and write together
      dop(1, 1, 32'h28, 32'h55AA55AA, 4'hF, rd, er, lat);
      chk("rdwr_err", 32'(er), 1);
      chk("rdwr_dat", rd, 0);
      dop(1, 0, 32'h28, 0, 4'hF, rd, er, lat);
      chk("rdwr_stored", rd, 32'h55AA55AA);

      // load accepted on the store's RESP edge
      data_wr_en_ma = 1; data_addr = 32'h2C;
      data_wr = 32'h0F0F0F0F; data_rd_en_ctrl = 4'hF;
      @(posedge clk);
      wait_rdy(lat);
      data_wr_en_ma = 0; data_rd_en_ma = 1;
      @(posedge clk);
      wait_rdy(lat);
      data_rd_en_ma = 0;
      chk("fwd_lat", lat, 3);
      chk("fwd_dat", data_rd, 32'h0F0F0F0F);
      @(posedge clk); #1;

      // sustained load throughput
      data_rd_en_ma = 1; data_addr = 32'h10; data_rd_en_ctrl = 4'hF;
      @(posedge clk);
      t1 = 0; t2 = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (data_ready) begin
            if (t1 == 0) t1 = i;
            else begin
               t2 = i;
               break;
            end
         end
      end
      data_rd_en_ma = 0;
      @(posedge clk); #1;
      chk("thru_first", t1, 3);
      chk("thru_second", t2, 6);

      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
